// File: rtl/instr_prefetch_pkg.sv
// instr_prefetch_pkg: shared types and constants for the instruction prefetch unit
package instr_prefetch_pkg;

    localparam logic [31:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } inflight_t;

endpackage

// File: rtl/instr_prefetch_fifo.sv
// instr_prefetch_fifo: flip-flop FIFO of fetched {pc, instr} entries with flush
module instr_prefetch_fifo
    import instr_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   mem_d [DEPTH];
    logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic           do_push, do_pop, full;

    // flush discards any push and empties the queue; pop on empty is ignored
    always_comb begin
        do_push = push && !flush;
        do_pop  = pop && (cnt_q != '0);
        full    = cnt_q == (AW+1)'(DEPTH);
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = push_entry;
        wr_d    = flush ? '0 : wr_q + AW'(do_push);
        rd_d    = flush ? '0 : rd_q + AW'(do_pop);
        cnt_d   = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // state registers, storage included, cleared on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign head  = mem_q[rd_q];
    assign count = cnt_q;

    // the upstream credit scheme must never push into a full queue
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(do_push && full && !do_pop));

endmodule

// File: rtl/instr_prefetch.sv
// instr_prefetch: credit-based instruction prefetcher with fixed-latency memory and redirect flush
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imAddr,
    input  logic [31:0] imData,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic        instrValid,
    output logic [31:0] instrData,
    output logic [31:0] instrPc,
    input  logic        instrReady
);

    localparam int CW = $clog2(DEPTH + LATENCY + 1) + 1;

    logic [31:0]           fetch_pc_q, fetch_pc_d;
    inflight_t             stage_q [LATENCY];
    inflight_t             stage_d [LATENCY];
    logic [$clog2(DEPTH):0] fifo_count;
    fetch_entry_t          head;
    logic [CW-1:0]         inflight_cnt, occupancy;
    logic                  pop, issue;

    // credit check, in-flight shift and next fetch PC; redirect blocks issue and kills in-flight reads
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < LATENCY; i++) inflight_cnt = inflight_cnt + CW'(stage_q[i].valid);
        pop        = instrValid && instrReady;
        occupancy  = CW'(fifo_count) + inflight_cnt - CW'(pop);
        issue      = !redirect && (occupancy < CW'(DEPTH));
        stage_d[0] = '{valid: issue, pc: fetch_pc_q};
        for (int i = 1; i < LATENCY; i++) stage_d[i] = '{valid: stage_q[i-1].valid && !redirect, pc: stage_q[i-1].pc};
        fetch_pc_d = redirect ? (redirectPc & ~32'h3) : issue ? fetch_pc_q + PC_INC : fetch_pc_q;
    end

    // fetch PC and in-flight tracking registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= '0;
            stage_q    <= '{default: '0};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            stage_q    <= stage_d;
        end
    end

    instr_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (stage_q[LATENCY-1].valid),
        .push_entry ('{pc: stage_q[LATENCY-1].pc, instr: imData}),
        .pop        (pop),
        .flush      (redirect),
        .head       (head),
        .count      (fifo_count)
    );

    assign imAddr     = {2'b00, fetch_pc_q[31:2]};
    assign instrValid = fifo_count != '0;
    assign instrData  = head.instr;
    assign instrPc    = head.pc;

endmodule

// File: tb/tb_instr_prefetch.sv
// tb_instr_prefetch: directed scoreboard bench for instr_prefetch with a fixed-latency memory model
module tb_instr_prefetch;

    localparam int LAT = 2;

    logic        clk, rst, redirect, instrReady, instrValid;
    logic [31:0] imAddr, imData, redirectPc, instrData, instrPc;
    logic [31:0] pipe [LAT];
    logic [63:0] exp_q [$];
    int          vectors, miscompares, cyc;

    instr_prefetch #(.LATENCY(LAT), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .imAddr     (imAddr),
        .imData     (imData),
        .redirect   (redirect),
        .redirectPc (redirectPc),
        .instrValid (instrValid),
        .instrData  (instrData),
        .instrPc    (instrPc),
        .instrReady (instrReady)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // memory: word at address a is 0x1000 + a, returned LAT cycles after the address
    always @(posedge clk) begin
        pipe[0] <= imAddr;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign imData = 32'h1000 + pipe[LAT-1];

    function automatic logic [63:0] ent(input logic [31:0] pc);
        return {pc, 32'h1000 + (pc >> 2)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // monitor: every accepted instruction is compared against the next expected entry
    always @(negedge clk) begin
        if (rst === 1'b1 && instrValid && instrReady) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_handshake: got pc=%h data=%h, want none", instrPc, instrData);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({instrPc, instrData} !== e) begin
                    miscompares++;
                    $display("FAIL handshake: got pc=%h data=%h, want pc=%h data=%h", instrPc, instrData, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        rst = 0; redirect = 0; redirectPc = 0; instrReady = 1;
        for (int i = 0; i < 10; i++) exp_q.push_back(ent(32'(i * 4)));
        #7;
        chk("reset_valid", 32'(instrValid), 0);
        chk("reset_data", instrData, 0);
        chk("reset_pc", instrPc, 0);
        chk("reset_imaddr", imAddr, 0);
        @(negedge clk);
        rst = 1;
        cyc = 0;
        repeat (13) begin
            step();
            chk("stream_valid", 32'(instrValid), (cyc >= 3) ? 32'd1 : 32'd0);
            if (cyc == 3) begin
                chk("first_pc", instrPc, 0);
                chk("first_data", instrData, 32'h1000);
            end
        end
        #1 rst = 0;
        #1;
        chk("async_valid", 32'(instrValid), 0);
        chk("async_pc", instrPc, 0);
        chk("async_data", instrData, 0);
        chk("async_imaddr", imAddr, 0);
        instrReady = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        cyc = 0;
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(ent(32'h0));
        exp_q.push_back(ent(32'h4));
        exp_q.push_back(ent(32'h8));
        exp_q.push_back(ent(32'hC));
        for (int i = 0; i < 7; i++) exp_q.push_back(ent(32'h40 + 32'(i * 4)));
        exp_q.push_back(ent(32'hFFFFFFFC));
        exp_q.push_back(ent(32'h0));
        exp_q.push_back(ent(32'h4));
        exp_q.push_back(ent(32'h8));
        exp_q.push_back(ent(32'h200));
        exp_q.push_back(ent(32'h204));
        #1;
        chk("restart_imaddr", imAddr, 0);
        repeat (42) begin
            step();
            if (cyc == 9) begin
                chk("stall_imaddr", imAddr, 32'h4);
                chk("stall_valid", 32'(instrValid), 1);
                chk("stall_head_pc", instrPc, 0);
            end
            if (cyc == 10) instrReady = 1;
            if (cyc == 13) begin redirect = 1; redirectPc = 32'h40; end
            if (cyc == 14) redirect = 0;
            if (cyc >= 14 && cyc <= 16) chk("redir_gap", 32'(instrValid), 0);
            if (cyc == 17) begin
                chk("redir_valid", 32'(instrValid), 1);
                chk("redir_pc", instrPc, 32'h40);
            end
            if (cyc == 23) begin redirect = 1; redirectPc = 32'hFFFFFFFE; end
            if (cyc == 24) begin redirect = 0; chk("wrap_imaddr_hi", imAddr, 32'h3FFFFFFF); end
            if (cyc == 25) chk("wrap_imaddr_lo", imAddr, 0);
            if (cyc >= 24 && cyc <= 26) chk("wrap_gap", 32'(instrValid), 0);
            if (cyc == 27) begin
                chk("wrap_pc", instrPc, 32'hFFFFFFFC);
                chk("wrap_data", instrData, 32'h40000FFF);
            end
            if (cyc == 30) begin redirect = 1; redirectPc = 32'h100; end
            if (cyc == 31) redirectPc = 32'h200;
            if (cyc == 32) begin redirect = 0; chk("b2b_imaddr", imAddr, 32'h80); end
            if (cyc >= 31 && cyc <= 34) chk("b2b_gap", 32'(instrValid), 0);
            if (cyc == 35) chk("b2b_pc", instrPc, 32'h200);
            if (cyc == 37) instrReady = 0;
        end
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
